// File: rtl/ms_mul_arbiter.sv
// Round-robin arbiter that shares one serial multiplier among NUM_REQ requesters.
// Optional WAIT watchdog enabled by defining MS_MUL_ARB_TIMEOUT_EN.
module ms_mul_arbiter #(
  parameter int unsigned DATA_WIDTH  = 5,
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned RES_WIDTH   = 2 * DATA_WIDTH,
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_REQ-1:0]                  req_valid,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  req_a,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  req_b,
  output logic [NUM_REQ-1:0]                  req_ready,
  output logic                                mul_en,
  output logic [1:0][DATA_WIDTH-1:0]          mul_data_in,
  input  logic [RES_WIDTH-1:0]                mul_data_out,
  input  logic                                mul_done,
  output logic                                rsp_valid,
  output logic [$clog2(NUM_REQ)-1:0]          rsp_id,
  output logic [RES_WIDTH-1:0]                rsp_data,
  input  logic                                rsp_ready,
  output logic                                rsp_err
);

  localparam int unsigned ID_W = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYC < 1) begin : g_param_check
    $error("ms_mul_arbiter: illegal parameter set");
  end

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;

  state_e                      state_q, state_d;
  logic [ID_W-1:0]             ptr_q, ptr_d;
  logic [ID_W-1:0]             id_q, id_d;
  logic [1:0][DATA_WIDTH-1:0]  opnd_q, opnd_d;
  logic [RES_WIDTH-1:0]        data_q, data_d;
  logic                        any_req;
  logic [ID_W-1:0]             win;

`ifdef MS_MUL_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
`endif

  // Round-robin search starting at the pointer.
  always_comb begin : arb
    int unsigned k;
    any_req = 1'b0;
    win     = ptr_q;
    k       = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      k = int'(ptr_q) + i;
      if (k >= NUM_REQ) k = k - NUM_REQ;
      if (!any_req && req_valid[ID_W'(k)]) begin
        any_req = 1'b1;
        win     = ID_W'(k);
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      opnd_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      opnd_q  <= opnd_d;
      data_q  <= data_d;
    end
  end

`ifdef MS_MUL_ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
`endif

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    opnd_d  = opnd_q;
    data_d  = data_q;
`ifdef MS_MUL_ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = err_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (any_req) begin
          id_d      = win;
          opnd_d[0] = req_a[win];
          opnd_d[1] = req_b[win];
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: begin
`ifdef MS_MUL_ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (mul_done) begin
          data_d  = mul_data_out;
`ifdef MS_MUL_ARB_TIMEOUT_EN
          err_d   = 1'b0;
`endif
          state_d = S_RESP;
        end
`ifdef MS_MUL_ARB_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          data_d  = '0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      S_RESP: begin
        if (rsp_ready) begin
          ptr_d   = (id_q == ID_W'(NUM_REQ - 1)) ? '0 : id_q + ID_W'(1);
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Strobes decoded from state; the grant is gated so it stays low during reset.
  always_comb begin
    req_ready = '0;
    mul_en    = 1'b0;
    rsp_valid = 1'b0;
    if (state_q == S_IDLE && any_req && rst) req_ready[win] = 1'b1;
    if (state_q == S_ISSUE) mul_en = 1'b1;
    if (state_q == S_RESP) rsp_valid = 1'b1;
  end

  assign mul_data_in = opnd_q;
  assign rsp_id      = id_q;
  assign rsp_data    = data_q;
`ifdef MS_MUL_ARB_TIMEOUT_EN
  assign rsp_err     = err_q;
`else
  assign rsp_err     = 1'b0;
`endif

endmodule

// File: tb/tb_ms_mul_arbiter.sv
// Directed bench for ms_mul_arbiter with a fixed-latency multiplier model.
module tb_ms_mul_arbiter;

  localparam int unsigned DW  = 5;
  localparam int unsigned NR  = 4;
  localparam int unsigned RW  = 10;
  localparam int unsigned LAT = 3;

  logic                     clk = 1'b0;
  logic                     rst = 1'b0;
  logic [NR-1:0]            req_valid = '0;
  logic [NR-1:0][DW-1:0]    req_a = '0;
  logic [NR-1:0][DW-1:0]    req_b = '0;
  logic [NR-1:0]            req_ready;
  logic                     mul_en;
  logic [1:0][DW-1:0]       mul_data_in;
  logic [RW-1:0]            mul_data_out;
  logic                     mul_done;
  logic                     rsp_valid;
  logic [1:0]               rsp_id;
  logic [RW-1:0]            rsp_data;
  logic                     rsp_ready = 1'b0;
  logic                     rsp_err;

  logic [RW-1:0] mul_res = '0;
  int            mul_cnt = 0;
  logic          mul_busy = 1'b0;
  logic          mul_stall = 1'b0;
  logic          force_done = 1'b0;

  int total = 0;
  int bad   = 0;

  ms_mul_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .RES_WIDTH(RW), .TIMEOUT_CYC(8)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .mul_en(mul_en), .mul_data_in(mul_data_in),
    .mul_data_out(mul_data_out), .mul_done(mul_done), .rsp_valid(rsp_valid),
    .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_ready(rsp_ready), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  // Multiplier: result LAT cycles after mul_en; force_done injects a stray strobe with junk data.
  always @(posedge clk) begin
    if (mul_en) begin
      mul_res  <= RW'(mul_data_in[0]) * RW'(mul_data_in[1]);
      mul_cnt  <= LAT;
      mul_busy <= 1'b1;
    end else if (mul_busy) begin
      if (mul_cnt == 1) mul_busy <= 1'b0;
      mul_cnt <= mul_cnt - 1;
    end
  end
  assign mul_done     = (mul_busy && mul_cnt == 1 && !mul_stall) || force_done;
  assign mul_data_out = force_done ? RW'(10'h3FF) : mul_res;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  int unsigned rr_id[5]   = '{0, 1, 2, 3, 0};
  int unsigned rr_prod[5] = '{2, 6, 12, 20, 2};

  initial begin
    // Reset state, with a request pending that must not be granted.
    req_valid = 4'b1111;
    step(2);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_mul_en", mul_en, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_mul_data_in", mul_data_in, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_rsp_data", rsp_data, 0);

    // Single request: requester 2, 7*9.
    req_valid = 4'b0100;
    req_a[2] = 5'd7; req_b[2] = 5'd9;
    rst = 1'b1;
    #1;
    chk("single_grant", req_ready, 4'b0100);
    step(1);
    chk("single_ready_drop", req_ready, 0);
    chk("single_mul_en", mul_en, 1);
    chk("single_operands", mul_data_in, {5'd9, 5'd7});
    req_valid = 4'b0000;
    step(1);
    chk("single_wait_en_low", mul_en, 0);
    chk("single_wait_operands", mul_data_in, {5'd9, 5'd7});
    step(2);
    chk("single_not_yet", rsp_valid, 0);
    step(1);
    chk("single_rsp_valid", rsp_valid, 1);
    chk("single_rsp_id", rsp_id, 2);
    chk("single_rsp_data", rsp_data, 63);
    chk("single_rsp_err", rsp_err, 0);
    rsp_ready = 1'b1;
    step(1);
    chk("single_back_idle", rsp_valid, 0);

    // All four requesting from a fresh reset: grant order 0,1,2,3,0.
    rst = 1'b0;
    step(1);
    for (int i = 0; i < NR; i++) begin
      req_a[i] = DW'(i + 1);
      req_b[i] = DW'(i + 2);
    end
    rst = 1'b1;
    req_valid = 4'b1111;
    #1;
    for (int t = 0; t < 5; t++) begin
      chk("rr_grant", req_ready, 32'(1) << rr_id[t]);
      step(5);
      chk("rr_rsp_valid", rsp_valid, 1);
      chk("rr_rsp_id", rsp_id, rr_id[t]);
      chk("rr_rsp_data", rsp_data, rr_prod[t]);
      if (t < 4) step(1);
    end
    req_valid = 4'b0000;
    step(1);
    chk("rr_idle_after", req_ready, 0);

    // Back-pressure: response held 10 cycles while others request and stray dones arrive.
    req_valid = 4'b0010;
    req_a[1] = 5'd3; req_b[1] = 5'd5;
    rsp_ready = 1'b0;
    #1;
    chk("bp_grant", req_ready, 4'b0010);
    step(1);
    req_valid = 4'b1111;
    #1;
    chk("bp_no_grant_issue", req_ready, 0);
    step(4);
    for (int i = 0; i < 10; i++) begin
      chk("bp_rsp_valid", rsp_valid, 1);
      chk("bp_rsp_id", rsp_id, 1);
      chk("bp_rsp_data", rsp_data, 15);
      chk("bp_no_grant", req_ready, 0);
      force_done = (i % 3 == 0);
      step(1);
    end
    force_done = 1'b0;
    rsp_ready = 1'b1;
    step(1);
    chk("bp_next_grant", req_ready, 4'b0100);
    rsp_ready = 1'b0;

    // Reset asserted in WAIT, then requester 3 alone after release.
    step(2);
    rst = 1'b0;
    #1;
    chk("midrst_req_ready", req_ready, 0);
    chk("midrst_mul_en", mul_en, 0);
    chk("midrst_rsp_valid", rsp_valid, 0);
    chk("midrst_mul_data_in", mul_data_in, 0);
    chk("midrst_rsp_id", rsp_id, 0);
    chk("midrst_rsp_data", rsp_data, 0);
    chk("midrst_rsp_err", rsp_err, 0);
    step(2);
    req_valid = 4'b1000;
    req_a[3] = 5'd6; req_b[3] = 5'd11;
    rsp_ready = 1'b1;
    rst = 1'b1;
    #1;
    chk("postrst_grant", req_ready, 4'b1000);
    step(5);
    chk("postrst_rsp_valid", rsp_valid, 1);
    chk("postrst_rsp_id", rsp_id, 3);
    chk("postrst_rsp_data", rsp_data, 66);
    req_valid = 4'b0000;
    step(1);

    // Full-width product 31*31.
    req_valid = 4'b0001;
    req_a[0] = 5'd31; req_b[0] = 5'd31;
    #1;
    chk("max_grant", req_ready, 4'b0001);
    step(5);
    chk("max_rsp_valid", rsp_valid, 1);
    chk("max_rsp_id", rsp_id, 0);
    chk("max_rsp_data", rsp_data, 961);
    req_valid = 4'b0000;
    step(1);
    chk("max_back_idle", rsp_valid, 0);

`ifdef MS_MUL_ARB_TIMEOUT_EN
    // Multiplier never answers: timeout response 8 cycles after entering WAIT.
    mul_stall = 1'b1;
    rsp_ready = 1'b0;
    req_valid = 4'b0010;
    #1;
    chk("to_grant", req_ready, 4'b0010);
    step(1);
    req_valid = 4'b0000;
    step(8);
    chk("to_not_yet", rsp_valid, 0);
    step(1);
    chk("to_rsp_valid", rsp_valid, 1);
    chk("to_rsp_err", rsp_err, 1);
    chk("to_rsp_data", rsp_data, 0);
    chk("to_rsp_id", rsp_id, 1);
    force_done = 1'b1;
    step(1);
    force_done = 1'b0;
    chk("to_stray_data", rsp_data, 0);
    chk("to_stray_err", rsp_err, 1);
    mul_stall = 1'b0;
    rsp_ready = 1'b1;
    step(1);
    chk("to_back_idle", rsp_valid, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/ms_mul_arbiter.md
MS_MUL_ARBITER -- requirements
Module: ms_mul_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 5, operand width in bits.
REQ-002 SHALL have parameter NUM_REQ, default 4, number of requesters (2..8).
REQ-003 SHALL have parameter RES_WIDTH, default 2*DATA_WIDTH, product width in bits.
REQ-004 SHALL have parameter TIMEOUT_CYC, default 64, watchdog limit in cycles (used only under the macro in REQ-024).
REQ-005 SHALL have port clk, input, 1, the single clock.
REQ-006 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port req_valid, input, NUM_REQ, per-requester operation request.
REQ-008 SHALL have port req_a and req_b, input, NUM_REQ x DATA_WIDTH each, per-requester operands.
REQ-009 SHALL have port req_ready, output, NUM_REQ, one-hot grant/accept strobe.
REQ-010 SHALL have ports mul_en (output, 1), mul_data_in (output, 2 x DATA_WIDTH), mul_data_out (input, RES_WIDTH) and mul_done (input, 1), all connecting to the shared serial multiplier.
REQ-011 SHALL have ports rsp_valid (output, 1), rsp_id (output, clog2(NUM_REQ)), rsp_data (output, RES_WIDTH) and rsp_ready (input, 1).
REQ-012 SHALL have port rsp_err, output, 1, which is high when the response was produced by a timeout.

Function
REQ-013 SHALL implement FSM states IDLE, ISSUE, WAIT and RESP.
REQ-014 SHALL, in IDLE with any req_valid set, select the winner round-robin, starting the search at the index after the last winner (reset pointer 0, so requester 0 has top priority after reset).
REQ-015 SHALL, in that IDLE cycle, pulse req_ready[winner] for exactly one cycle, latch req_a and req_b of the winner into mul_data_in[0] and mul_data_in[1], latch the winner id, and go to ISSUE.
REQ-016 SHALL, in ISSUE, assert mul_en for exactly one cycle and then go to WAIT.
REQ-017 SHALL, in WAIT, hold mul_data_in stable and keep mul_en low.
REQ-018 SHALL, in WAIT, on the first cycle mul_done is high, capture mul_data_out into rsp_data and go to RESP.
REQ-019 SHALL, in RESP, hold rsp_valid high with rsp_id and rsp_data stable until rsp_ready is high.
REQ-020 SHALL, in a RESP cycle with rsp_ready high, complete the transfer, advance the round-robin pointer to winner+1 (mod NUM_REQ), and return to IDLE; a grant is possible at the earliest in the next cycle, so there is 1 bubble between responses.
REQ-021 SHALL ignore mul_done outside WAIT, and SHALL ignore req_valid outside IDLE (req_ready stays low there).
REQ-022 SHALL, when a single requester holds req_valid continuously, serve it every transaction; when all requesters hold it, serve them in the order 0,1,2,3,0...
REQ-023 SHALL make the minimum latency from grant to rsp_valid equal to multiplier latency + 2 cycles (ISSUE + capture).

Configuration
REQ-024 SHALL, with macro MS_MUL_ARB_TIMEOUT_EN defined, run a WAIT-cycle counter and, on reaching TIMEOUT_CYC without mul_done, enter RESP with rsp_data = 0 and rsp_err = 1; a later stray mul_done SHALL be ignored.
REQ-025 SHALL, without MS_MUL_ARB_TIMEOUT_EN, contain no counter, stay in WAIT indefinitely until mul_done, and tie rsp_err to 0.

Reset
REQ-026 SHALL, while rst is low, asynchronously force state IDLE, pointer 0, and req_ready, mul_en, rsp_valid and rsp_err to 0, and mul_data_in, rsp_id, rsp_data and the timeout counter to 0.
REQ-027 SHALL, on reset asserted mid-transaction (ISSUE, WAIT or RESP), drop the transaction without producing a response; the first grant after release SHALL follow the rules of REQ-014.

Verification
REQ-028 SHALL cover: single request, req 2 with a=7, b=9 -> req_ready[2] pulses once, mul_en pulses next cycle, then rsp_valid with rsp_id=2, rsp_data=63.
REQ-029 SHALL cover: all 4 req_valid held with rsp_ready=1 -> grant order 0,1,2,3,0 with exactly one bubble cycle after each response.
REQ-030 SHALL cover: rsp_ready held low 10 cycles in RESP -> rsp_valid, rsp_id and rsp_data stable, no new req_ready, and mul_done pulses are ignored.
REQ-031 SHALL cover: rst driven low during WAIT -> all outputs 0 immediately; after release with req 3 only -> requester 3 is granted and its correct product is returned.
REQ-032 SHALL cover: with MS_MUL_ARB_TIMEOUT_EN and TIMEOUT_CYC=8, mul_done never asserted -> rsp_valid 8 cycles after entering WAIT, rsp_err=1, rsp_data=0.
REQ-033 SHALL cover: a=31, b=31 at DATA_WIDTH=5 -> rsp_data=961 with the full RES_WIDTH and no truncation.
